// File: rtl/cgra_context_loader.sv
// cgra_context_loader: steers handshaken context words into per-PE cache slots, then runs the array until halt
// Optional parity check on incoming words when CFG_PARITY_EN is defined.
module cgra_context_loader #(
  parameter int width  = 120,
  parameter int NUM_PE = 16,
  parameter int PE_W   = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_req,
  input  logic              halt,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PE_W-1:0]   cfg_pe,
  input  logic [width:0]    cfg_word,
  input  logic              cfg_last,
`ifdef CFG_PARITY_EN
  input  logic              cfg_par,
  output logic              par_err,
`endif
  output logic [width:0]    data,
  output logic [NUM_PE-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              start,
  output logic              busy,
  output logic              ovf_err
);
  typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] cnt [NUM_PE];
  logic [ADDR_W:0] cur;
  logic pe_ok, ovf, acc, par_ok;
`ifdef CFG_PARITY_EN
  assign par_ok = (^{cfg_pe, cfg_word}) == cfg_par;
`else
  assign par_ok = 1'b1;
`endif
  assign pe_ok = 32'(cfg_pe) < NUM_PE;
  assign cur   = pe_ok ? cnt[cfg_pe] : '0;
  // counters saturate at DEPTH, so a full PE keeps dropping words
  assign ovf   = !pe_ok || cur == (ADDR_W+1)'(DEPTH);
  assign acc   = cfg_valid && cfg_ready;
  always_comb begin
    state_n   = state;
    cfg_ready = state == LOAD;
    start     = state == RUN;
    busy      = state != IDLE;
    case (state)
      IDLE:    state_n = load_req ? LOAD : IDLE;
      LOAD:    state_n = (acc && cfg_last) ? ARM : LOAD;
      ARM:     state_n = RUN;
      default: state_n = halt ? IDLE : RUN;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      data    <= '0;
      wr_en   <= '0;
      wr_addr <= '0;
      ovf_err <= 1'b0;
      cnt     <= '{default: '0};
`ifdef CFG_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      wr_en <= '0;
      if (state == IDLE && load_req) begin
        cnt     <= '{default: '0};
        ovf_err <= 1'b0;
`ifdef CFG_PARITY_EN
        par_err <= 1'b0;
`endif
      end
      if (acc) begin
        data <= cfg_word;
        if (ovf) ovf_err <= 1'b1;
`ifdef CFG_PARITY_EN
        if (!par_ok) par_err <= 1'b1;
`endif
        if (!ovf && par_ok) begin
          wr_en       <= {{(NUM_PE-1){1'b0}}, 1'b1} << cfg_pe;
          wr_addr     <= cur[ADDR_W-1:0];
          cnt[cfg_pe] <= cur + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cgra_context_loader.sv
// tb_cgra_context_loader: directed vectors for the context loader, hand-computed expectations
module tb_cgra_context_loader;
  logic CLK = 1'b0, RST = 1'b1, load_req = 1'b0, halt = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
  logic [3:0] cfg_pe = '0;
  logic [120:0] cfg_word = '0;
  logic cfg_ready, start, busy, ovf_err;
  logic [120:0] data;
  logic [15:0] wr_en;
  logic [3:0] wr_addr;
  logic par_flip = 1'b0;
`ifdef CFG_PARITY_EN
  logic cfg_par, par_err;
  assign cfg_par = (^{cfg_pe, cfg_word}) ^ par_flip;
`endif
  int errs = 0, checks = 0;

  cgra_context_loader dut (
    .CLK(CLK), .RST(RST), .load_req(load_req), .halt(halt),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pe(cfg_pe),
    .cfg_word(cfg_word), .cfg_last(cfg_last),
`ifdef CFG_PARITY_EN
    .cfg_par(cfg_par), .par_err(par_err),
`endif
    .data(data), .wr_en(wr_en), .wr_addr(wr_addr), .start(start),
    .busy(busy), .ovf_err(ovf_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] pe, input logic [120:0] w, input logic last);
    cfg_valid = 1'b1;
    cfg_pe    = pe;
    cfg_word  = w;
    cfg_last  = last;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic begin_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  initial begin
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_data", data, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_ovf", ovf_err, 0);
    RST = 1'b0;
    tick();
    // three words to PE 2
    begin_load();
    check("t1_busy", busy, 1);
    check("t1_ready", cfg_ready, 1);
    for (int i = 0; i < 3; i++) begin
      send(4'd2, 121'(32'hA0 + i), i == 2);
      check("t1_wr_en", wr_en, 16'h0004);
      check("t1_wr_addr", wr_addr, i);
      check("t1_data", data, 32'hA0 + i);
    end
    check("t1_arm_ready", cfg_ready, 0);
    check("t1_arm_start", start, 0);
    tick();
    check("t1_start", start, 1);
    check("t1_wr_idle", wr_en, 0);
    do_halt();
    check("t1_halt_start", start, 0);
    check("t1_halt_busy", busy, 0);
    // 17 words to PE 5: the 17th overflows but still ends the session
    begin_load();
    for (int i = 0; i < 16; i++) begin
      send(4'd5, 121'(i), 1'b0);
      check("t2_wr_en", wr_en, 16'h0020);
      check("t2_wr_addr", wr_addr, i);
    end
    check("t2_no_ovf", ovf_err, 0);
    send(4'd5, 121'(99), 1'b1);
    check("t2_drop", wr_en, 0);
    check("t2_ovf", ovf_err, 1);
    tick();
    check("t2_start", start, 1);
    // halt and load_req together in RUN
    halt = 1'b1;
    load_req = 1'b1;
    tick();
    halt = 1'b0;
    load_req = 1'b0;
    check("t4_start", start, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", cfg_ready, 0);
    tick();
    check("t4_still_idle", busy, 0);
    check("t4_ovf_sticky", ovf_err, 1);
    // gapped valid, PEs 0,15,0
    begin_load();
    check("t3_ovf_clr", ovf_err, 0);
    cfg_pe = 4'd7;
    tick();
    check("t3_gap0", wr_en, 0);
    send(4'd0, 121'h111, 1'b0);
    check("t3_pe0_a", wr_en, 16'h0001);
    check("t3_pe0_a_addr", wr_addr, 0);
    tick();
    check("t3_gap1", wr_en, 0);
    check("t3_data_hold", data, 121'h111);
    send(4'd15, 121'h222, 1'b0);
    check("t3_pe15", wr_en, 16'h8000);
    check("t3_pe15_addr", wr_addr, 0);
    tick();
    send(4'd0, 121'h333, 1'b1);
    check("t3_pe0_b", wr_en, 16'h0001);
    check("t3_pe0_b_addr", wr_addr, 1);
    tick();
    check("t3_start", start, 1);
    do_halt();
    // async reset mid-load
    begin_load();
    send(4'd3, 121'h1, 1'b0);
    send(4'd3, 121'h2, 1'b0);
    check("t5_pre_wr", wr_en, 16'h0008);
    check("t5_pre_addr", wr_addr, 1);
    #2 RST = 1'b1;
    #1;
    check("t5_async_wr", wr_en, 0);
    check("t5_async_addr", wr_addr, 0);
    check("t5_async_data", data, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", cfg_ready, 0);
    tick();
    RST = 1'b0;
    tick();
    begin_load();
    send(4'd3, 121'h3, 1'b1);
    check("t5_restart_wr", wr_en, 16'h0008);
    check("t5_restart_addr", wr_addr, 0);
    tick();
    do_halt();
`ifdef CFG_PARITY_EN
    begin_load();
    check("t6_par_clr", par_err, 0);
    send(4'd1, 121'h5, 1'b0);
    check("t6_first_addr", wr_addr, 0);
    par_flip = 1'b1;
    send(4'd1, 121'h6, 1'b0);
    par_flip = 1'b0;
    check("t6_bad_wr", wr_en, 0);
    check("t6_par_err", par_err, 1);
    send(4'd1, 121'h7, 1'b1);
    check("t6_good_wr", wr_en, 16'h0002);
    check("t6_good_addr", wr_addr, 1);
    tick();
    do_halt();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
